game_round_sequencer: RTL and testbench

- Sequences one game session of ROUNDS rounds once the speed selection is committed (control=1 from the speed-select stage).
- Each round: request a new random number, show it for a speed-dependent window, open a speed-dependent answer window, then score the round.
- Sits between the speed-select stage, the random-number generator and the display/input logic; owns all game timing.

---
 rtl/game_round_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_game_round_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/game_round_sequencer.sv
// Game session sequencer: per round requests a random number, shows it, opens an
// answer window and scores the result, for ROUNDS rounds after the speed is committed.
module game_round_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int SHOW_N   = 3000,
    parameter int SHOW_I   = 2000,
    parameter int SHOW_A   = 1000,
    parameter int ANS_N    = 5000,
    parameter int ANS_I    = 3000,
    parameter int ANS_A    = 1500,
    parameter int ROUNDS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gameSpeed,
    input  logic       control,
    input  logic       rngAck,
    input  logic       answerValid,
    input  logic       answerCorrect,
    output logic       rngReq,
    output logic       showEn,
    output logic       answerEn,
    output logic       timeout,
    output logic       roundDone,
    output logic [3:0] roundNum,
    output logic [3:0] score,
    output logic       gameOver
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_SHOW   = 3'd2,
        S_ANSWER = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_speed, w_speed_next;
    logic [15:0] r_presc, w_presc_next;
    logic [15:0] r_tick, w_tick_next;
    logic [3:0]  r_round, w_round_next;
    logic [3:0]  r_score, w_score_next;
    logic        r_timeout, w_timeout_next;
    logic        r_round_done, w_round_done_next;
    logic        r_rng_req, r_show_en, r_answer_en, r_game_over;
    logic [15:0] w_show_lim, w_ans_lim;
    logic        w_wrap;

    // Speed code 11 falls into the default branch and gets normal timing.
    always_comb begin
        case (r_speed)
            2'b01:   begin w_show_lim = 16'(SHOW_I); w_ans_lim = 16'(ANS_I); end
            2'b10:   begin w_show_lim = 16'(SHOW_A); w_ans_lim = 16'(ANS_A); end
            default: begin w_show_lim = 16'(SHOW_N); w_ans_lim = 16'(ANS_N); end
        endcase
    end

    assign w_wrap = (r_presc == 16'(TICK_DIV - 1));

    always_comb begin
        w_state_next      = r_state;
        w_speed_next      = r_speed;
        w_presc_next      = r_presc;
        w_tick_next       = r_tick;
        w_round_next      = r_round;
        w_score_next      = r_score;
        w_timeout_next    = 1'b0;
        w_round_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (control) begin
                    w_speed_next = gameSpeed;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (rngAck) begin
                    w_state_next = S_SHOW;
                    w_presc_next = 16'd0;
                    w_tick_next  = 16'd0;
                end
            end
            S_SHOW: begin
                if (w_wrap) begin
                    w_presc_next = 16'd0;
                    if (r_tick == w_show_lim - 16'd1) begin
                        w_state_next = S_ANSWER;
                        w_tick_next  = 16'd0;
                    end else begin
                        w_tick_next = r_tick + 16'd1;
                    end
                end else begin
                    w_presc_next = r_presc + 16'd1;
                end
            end
            S_ANSWER: begin
                // An answer on the last window cycle takes priority over expiry.
                if (answerValid) begin
                    if (answerCorrect && r_score != 4'd15)
                        w_score_next = r_score + 4'd1;
                    w_state_next      = S_RESULT;
                    w_round_next      = r_round + 4'd1;
                    w_round_done_next = 1'b1;
                    w_presc_next      = 16'd0;
                    w_tick_next       = 16'd0;
                end else if (w_wrap) begin
                    w_presc_next = 16'd0;
                    if (r_tick == w_ans_lim - 16'd1) begin
                        w_state_next      = S_RESULT;
                        w_tick_next       = 16'd0;
                        w_timeout_next    = 1'b1;
                        w_round_next      = r_round + 4'd1;
                        w_round_done_next = 1'b1;
                    end else begin
                        w_tick_next = r_tick + 16'd1;
                    end
                end else begin
                    w_presc_next = r_presc + 16'd1;
                end
            end
            S_RESULT: begin
                if (r_round == 4'(ROUNDS))
                    w_state_next = S_DONE;
                else
                    w_state_next = S_REQ;
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_speed_next = 2'b00;
                w_presc_next = 16'd0;
                w_tick_next  = 16'd0;
                w_round_next = 4'd0;
                w_score_next = 4'd0;
            end
        endcase
    end

    // Enables are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_speed      <= 2'b00;
            r_presc      <= 16'd0;
            r_tick       <= 16'd0;
            r_round      <= 4'd0;
            r_score      <= 4'd0;
            r_timeout    <= 1'b0;
            r_round_done <= 1'b0;
            r_rng_req    <= 1'b0;
            r_show_en    <= 1'b0;
            r_answer_en  <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_speed      <= w_speed_next;
            r_presc      <= w_presc_next;
            r_tick       <= w_tick_next;
            r_round      <= w_round_next;
            r_score      <= w_score_next;
            r_timeout    <= w_timeout_next;
            r_round_done <= w_round_done_next;
            r_rng_req    <= (w_state_next == S_REQ);
            r_show_en    <= (w_state_next == S_SHOW);
            r_answer_en  <= (w_state_next == S_ANSWER);
            r_game_over  <= (w_state_next == S_DONE);
        end
    end

    assign rngReq    = r_rng_req;
    assign showEn    = r_show_en;
    assign answerEn  = r_answer_en;
    assign timeout   = r_timeout;
    assign roundDone = r_round_done;
    assign roundNum  = r_round;
    assign score     = r_score;
    assign gameOver  = r_game_over;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: a table of rounds with hand-computed window lengths
// and results, plus hand sequences for idle, mid-SHOW reset and DONE hold.
module tb_game_round_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] gameSpeed;
    logic       control;
    logic       rngAck;
    logic       answerValid;
    logic       answerCorrect;
    logic       rngReq;
    logic       showEn;
    logic       answerEn;
    logic       timeout;
    logic       roundDone;
    logic [3:0] roundNum;
    logic [3:0] score;
    logic       gameOver;

    int total = 0;
    int bad   = 0;

    game_round_sequencer #(
        .TICK_DIV(4), .SHOW_N(3), .SHOW_I(2), .SHOW_A(1),
        .ANS_N(5), .ANS_I(3), .ANS_A(2), .ROUNDS(2)
    ) dut (
        .clk(clk), .rst(rst), .gameSpeed(gameSpeed), .control(control),
        .rngAck(rngAck), .answerValid(answerValid), .answerCorrect(answerCorrect),
        .rngReq(rngReq), .showEn(showEn), .answerEn(answerEn), .timeout(timeout),
        .roundDone(roundDone), .roundNum(roundNum), .score(score), .gameOver(gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         do_reset;
        bit         start;
        logic [1:0] speed;
        int         ack_delay;
        int         ans_cycle;   // 0 = never answer
        bit         correct;
        int         exp_show;
        int         exp_ans;
        int         exp_timeout;
        int         exp_round;
        int         exp_score;
        int         exp_over;
    } row_t;

    row_t rows[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [14:0] all_outs();
        return {rngReq, showEn, answerEn, timeout, roundDone, roundNum, score, gameOver};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        control = 1'b0;
        rngAck = 1'b0;
        answerValid = 1'b0;
        answerCorrect = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b1;
    endtask

    task automatic run_row(input int idx, input row_t r);
        int n;
        int m;
        if (r.do_reset) do_reset();
        if (r.start) begin
            gameSpeed = r.speed;
            control = 1'b1;
            @(negedge clk);
            chk("rngreq_after_control", 32'(rngReq), 32'd1);
            control = 1'b0;
            gameSpeed = (r.speed == 2'b10) ? 2'b00 : 2'b10;
        end
        n = 0;
        while (!rngReq && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rngreq_wait", 32'(rngReq), 32'd1);
        for (int k = 0; k < r.ack_delay; k++) @(negedge clk);
        chk("rngreq_held", 32'(rngReq), 32'd1);
        rngAck = 1'b1;
        @(negedge clk);
        rngAck = 1'b0;
        chk("rngreq_drop", 32'(rngReq), 32'd0);
        n = 0;
        while (showEn && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("show_cycles", 32'(n), 32'(r.exp_show));
        m = 0;
        while (answerEn && m < 200) begin
            m++;
            if (m == r.ans_cycle) begin
                answerValid = 1'b1;
                answerCorrect = r.correct;
            end
            @(negedge clk);
            answerValid = 1'b0;
            answerCorrect = 1'b0;
        end
        chk("answer_cycles", 32'(m), 32'(r.exp_ans));
        chk("timeout", 32'(timeout), 32'(r.exp_timeout));
        chk("round_done", 32'(roundDone), 32'd1);
        chk("round_num", 32'(roundNum), 32'(r.exp_round));
        chk("score", 32'(score), 32'(r.exp_score));
        @(negedge clk);
        chk("pulses_cleared", 32'({timeout, roundDone}), 32'd0);
        chk("game_over", 32'(gameOver), 32'(r.exp_over));
        chk("next_req", 32'(rngReq), 32'(r.exp_over == 0));
        $display("row %0d: speed=%0d show=%0d ans=%0d timeout=%0d round=%0d score=%0d over=%0d",
                 idx, r.speed, n, m, r.exp_timeout, roundNum, score, gameOver);
        if (r.exp_over != 0) begin
            for (int k = 0; k < 5; k++) begin
                answerValid = (k == 1);
                answerCorrect = 1'b1;
                @(negedge clk);
            end
            answerValid = 1'b0;
            answerCorrect = 1'b0;
            chk("done_hold", 32'(all_outs()),
                32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(r.exp_round), 4'(r.exp_score), 1'b1}));
        end
    endtask

    initial begin
        int n;
        row_t r;
        rst = 1'b0;
        gameSpeed = 2'b00;
        control = 1'b0;
        rngAck = 1'b0;
        answerValid = 1'b0;
        answerCorrect = 1'b0;
        //         rst start speed ack ans cor show ans  to rnd sc ov
        rows[0] = '{1, 1, 2'b00, 3, 0, 0, 12, 20, 1, 1, 0, 0};
        rows[1] = '{0, 0, 2'b00, 1, 5, 1, 12, 5,  0, 2, 1, 1};
        rows[2] = '{1, 1, 2'b10, 2, 3, 1, 4,  3,  0, 1, 1, 0};
        rows[3] = '{0, 0, 2'b10, 0, 8, 1, 4,  8,  0, 2, 2, 1};
        rows[4] = '{1, 1, 2'b01, 0, 2, 0, 8,  2,  0, 1, 0, 0};
        rows[5] = '{0, 0, 2'b01, 4, 0, 0, 8,  12, 1, 2, 0, 1};
        rows[6] = '{1, 1, 2'b11, 1, 0, 0, 12, 20, 1, 1, 0, 0};
        rows[7] = '{1, 1, 2'b10, 1, 1, 1, 4,  1,  0, 1, 1, 0};

        @(negedge clk);
        do_reset();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (all_outs() != 15'd0) n++;
        end
        chk("idle_quiet", 32'(n), 32'd0);
        $display("idle: 20 cycles control=0, nonzero output cycles=%0d", n);

        for (int i = 0; i < 8; i++) run_row(i, rows[i]);

        // Abort mid-SHOW, then speed code 11 must give normal timing.
        do_reset();
        gameSpeed = 2'b10;
        control = 1'b1;
        @(negedge clk);
        control = 1'b0;
        rngAck = 1'b1;
        @(negedge clk);
        rngAck = 1'b0;
        chk("midshow_in_show", 32'(showEn), 32'd1);
        for (int k = 0; k < 2; k++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midshow_reset", 32'(all_outs()), 32'd0);
        @(negedge clk);
        chk("midshow_idle", 32'(all_outs()), 32'd0);
        $display("midshow reset: outputs=%0h", all_outs());
        r = '{0, 1, 2'b11, 2, 0, 0, 12, 20, 1, 1, 0, 0};
        run_row(8, r);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
